// File: rtl/prio_disp_pkg.sv
// Shared display constants for the priority-encoder display block:
// active-low seven-segment patterns, bit order {a,b,c,d,e,f,g,dp}.
package prio_disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Element 0 is the rightmost entry, so the list reads F down to 0.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

endpackage

// File: rtl/prio_encode_disp_seg_hex.sv
// Four-bit value to active-low hex digit, with a blanking override.
module seg_hex
  import prio_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);

  assign seg = blank ? SEG_BLANK : HEX_SEG[digit];

endmodule

// File: rtl/prio_encode_disp.sv
// Debounced switch vector -> highest-set-bit encoder with registered result,
// result-change counter and two hex displays.
module prio_encode_disp
  import prio_disp_pkg::*;
#(
  parameter  int N_IN      = 8,
  parameter  int DB_CYCLES = 16,
  localparam int W         = $clog2(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] sw,
  input  logic            en,
  input  logic            hold,
  output logic [W-1:0]    code,
  output logic            valid,
  output logic [W:0]      ledr,
  output logic [7:0]      seg0,
  output logic [7:0]      seg1,
  output logic [7:0]      chg_cnt
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [N_IN-1:0] sync1, sync2, sync_prev, sw_db;
  logic [CW-1:0]   db_cnt, cnt_next;
  logic [W-1:0]    enc_code, next_code;
  logic            any_set, next_valid, next_idle, idle;

  // Run length of the synchronised value, restarting at 1 whenever it moves.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_next = CW'(1);
    if (sync2 == sync_prev)
      cnt_next = (db_cnt == CW'(DB_CYCLES)) ? db_cnt : db_cnt + 1'b1;
  end

  // NOTE: non-blocking assignments for all flops; reset is asynchronous so a mid-debounce change is dropped at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      db_cnt    <= '0;
      sw_db     <= '0;
    end else begin
      sync1     <= sw;
      sync2     <= sync1;
      sync_prev <= sync2;
      db_cnt    <= cnt_next;
      if (cnt_next == CW'(DB_CYCLES) && sync2 != sw_db)
        sw_db <= sync2;
    end
  end

  // Later (higher) indices overwrite earlier ones, giving top-bit priority.
  always_comb begin
    enc_code = '0;
    for (int i = 0; i < N_IN; i++)
      if (sw_db[i]) enc_code = W'(i);
    any_set    = |sw_db;
    next_valid = en & any_set;
    next_code  = en ? enc_code : '0;
    next_idle  = en & ~any_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code    <= '0;
      valid   <= 1'b0;
      idle    <= 1'b0;
      chg_cnt <= '0;
    end else if (!hold) begin
      code  <= next_code;
      valid <= next_valid;
      idle  <= next_idle;
      if ({next_valid, next_code} != {valid, code})
        chg_cnt <= chg_cnt + 8'd1;
    end
  end

  assign ledr = {idle, code};

  seg_hex u_seg0 (
    .digit (4'(code)),
    .blank (!valid),
    .seg   (seg0)
  );

  seg_hex u_seg1 (
    .digit (chg_cnt[3:0]),
    .blank (1'b0),
    .seg   (seg1)
  );

endmodule

// File: doc/prio_encode_disp.md
PRIO_ENCODE_DISP -- requirements
Module: prio_encode_disp

Interface
REQ-001 SHALL have parameter N_IN, default 8, meaning input-vector width, legal range 2..16.
REQ-002 SHALL have parameter DB_CYCLES, default 16, meaning the consecutive stable cycles required to accept an input change, legal minimum 1.
REQ-003 SHALL define local W = clog2(N_IN), the code width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port sw, input, N_IN bits, raw switch vector, asynchronous to clk.
REQ-007 SHALL have port en, input, 1 bit, encoder enable, synchronous to clk.
REQ-008 SHALL have port hold, input, 1 bit, freezes displayed result, synchronous to clk.
REQ-009 SHALL have port code, output, W bits, registered index of highest set debounced bit.
REQ-010 SHALL have port valid, output, 1 bit, registered: en=1 and at least one debounced bit set.
REQ-011 SHALL have port ledr, output, W+1 bits: [W-1:0]=code, [W]=en & no debounced bit set (registered).
REQ-012 SHALL have port seg0, output, 8 bits, active-low hex digit of code; all segments off when valid=0.
REQ-013 SHALL have port seg1, output, 8 bits, active-low hex digit of chg_cnt[3:0].
REQ-014 SHALL have port chg_cnt, output, 8 bits, count of result changes, mod 256.

Function
REQ-015 SHALL pass sw through a 2-flop synchroniser per bit.
REQ-016 SHALL accept the synchronised vector into internal sw_db only after it has held one value for DB_CYCLES consecutive cycles; any change restarts the count.
REQ-017 SHALL ignore any sw pulse or glitch shorter than DB_CYCLES cycles (sw_db unchanged).
REQ-018 SHALL give a fixed latency of exactly DB_CYCLES+3 cycles from a stable sw change to updated code/valid/ledr/seg0 (2 sync + DB_CYCLES debounce + 1 output register).
REQ-019 SHALL encode with priority to the highest index; code=0 when no bit set or en=0.
REQ-020 SHALL sample en with 1-cycle latency into the output register (no debounce).
REQ-021 SHALL, while hold=1, keep code, valid, ledr, seg0 and chg_cnt unchanged, while synchroniser and debounce keep running.
REQ-022 SHALL, on hold falling, update outputs to the current sw_db/en result on the next edge.
REQ-023 SHALL increment chg_cnt by 1 on each edge where the registered {valid,code} pair takes a new value; 255 wraps to 0.
REQ-024 SHALL count en dropping while valid=1 as one change.
REQ-025 SHALL use segment bit order {a,b,c,d,e,f,g,dp}, MSB=a, active-low; dp always off; blank=0xFF; digits 0-F standard (e.g. 0=0x03, 1=0x9F, 5=0x49).

Reset
REQ-026 SHALL, on rst=1, immediately clear synchroniser, debounce counter and sw_db, independent of clk.
REQ-027 SHALL drive reset values code=0, valid=0, ledr=0, chg_cnt=0, seg0=0xFF, seg1=0x03.
REQ-028 SHALL, when reset asserts mid-debounce, discard the pending change, and SHALL restart debounce from the first post-reset edge.

Structure
REQ-029 SHALL place the hex-to-segment table constant and SEG_BLANK in shared package prio_disp_pkg.
REQ-030 SHALL implement the 4-bit-to-segment decode as sub-module seg_hex, instantiated twice (seg0, seg1).
REQ-031 SHALL make the debounce counter clog2(DB_CYCLES+1) bits wide, saturating.

Verification (N_IN=8, DB_CYCLES=4, latency 7)
REQ-032 SHALL check reset: rst pulse -> code=0, valid=0, ledr=0, chg_cnt=0, seg0=0xFF, seg1=0x03.
REQ-033 SHALL check en=1, sw=0x28 stable -> exactly 7 cycles later code=5, valid=1, ledr=4'b0101, seg0=0x49, chg_cnt=1, seg1=0x9F.
REQ-034 SHALL check glitch rejection: from sw=0x28, sw=0xA8 for 3 cycles then 0x28 -> code stays 5, chg_cnt unchanged.
REQ-035 SHALL check hold: hold=1, sw=0x01 for 20 cycles -> code stays 5; hold=0 -> next cycle code=0, valid=1, seg0=0x03, chg_cnt+1.
REQ-036 SHALL check en=0 with sw=0x00 debounced -> ledr[3]=0, valid=0, seg0=0xFF; en=1 -> next cycle ledr=4'b1000.
REQ-037 SHALL check 256 alternating result changes -> chg_cnt wraps to 0; rst asserted mid-debounce -> outputs return to reset values with no late update.
